// File: rtl/onehot_encoder_stream.sv
// ---------------------------------------------------------------------------
// onehot_encoder_stream
//   Streaming one-hot to binary encoder. An N-bit one-hot vector accepted on
//   the input handshake comes back as the M-bit index of its lowest set bit.
//   Zero and multi-hot vectors are flagged, and a sticky flag plus a
//   saturating counter record malformed results as they are delivered.
//   Two elastic register stages (S1 encode, S2 output) give full throughput
//   and lossless, order-preserving backpressure.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    input vector valid
//   in_ready    block can take in_data this cycle (combinational from out_ready)
//   in_data     N-bit one-hot vector
//   out_valid   result valid (registered)
//   out_ready   downstream accepts result
//   out_index   index of lowest set bit (0 while out_valid=0)
//   out_zero    input was all-zero (0 while out_valid=0)
//   out_multi   input had more than one bit set (0 while out_valid=0)
//   err_sticky  set by any delivered malformed result
//   err_count   saturating count of delivered malformed results
//   err_clear   clears err_sticky and err_count; wins over a same-edge error
// ---------------------------------------------------------------------------
module onehot_encoder_stream #(
    parameter int N     = 16,
    parameter int M     = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_index,
    output logic             out_zero,
    output logic             out_multi,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clear
);

    // Index of the lowest set bit; 0 for an all-zero vector. Scanning from
    // the top down lets the lowest hit overwrite any higher one. The result
    // is always a real bit position, so it never exceeds N-1.
    function automatic logic [M-1:0] lowest_index(input logic [N-1:0] vec);
        logic [M-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = M'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic is_multi(input logic [N-1:0] vec);
        return (vec & (vec - N'(1))) != N'(0);
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic           s1_valid_r;
    logic [M-1:0]   s1_idx_r;
    logic           s1_zero_r;
    logic           s1_multi_r;

    logic           s2_valid_r;
    logic [M-1:0]   s2_idx_r;
    logic           s2_zero_r;
    logic           s2_multi_r;

    logic             err_sticky_r;
    logic [CNT_W-1:0] err_count_r;

    logic s2_adv_s;
    logic s1_adv_s;
    logic err_xfer_s;

    // Stage advance terms and the malformed-delivery event.
    always_comb begin
        s2_adv_s   = ~s2_valid_r | out_ready;
        s1_adv_s   = ~s1_valid_r | s2_adv_s;
        err_xfer_s = s2_valid_r & out_ready & (s2_zero_r | s2_multi_r);
    end

    assign in_ready = s1_adv_s;

    // S1: encode the accepted vector; an empty slot is refilled (or emptied)
    // whenever it is allowed to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= '0;
            s1_zero_r  <= 1'b0;
            s1_multi_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            s1_idx_r   <= lowest_index(in_data);
            s1_zero_r  <= ~|in_data;
            s1_multi_r <= is_multi(in_data);
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_idx_r   <= s1_idx_r;
            s1_zero_r  <= s1_zero_r;
            s1_multi_r <= s1_multi_r;
        end
    end

    // S2: output register. Data is zeroed when the slot empties so that the
    // result fields read 0 whenever out_valid is low, straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_idx_r   <= '0;
            s2_zero_r  <= 1'b0;
            s2_multi_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_idx_r   <= s1_idx_r;
                s2_zero_r  <= s1_zero_r;
                s2_multi_r <= s1_multi_r;
            end else begin
                s2_idx_r   <= '0;
                s2_zero_r  <= 1'b0;
                s2_multi_r <= 1'b0;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_idx_r   <= s2_idx_r;
            s2_zero_r  <= s2_zero_r;
            s2_multi_r <= s2_multi_r;
        end
    end

    // Error accounting; err_clear takes priority over a same-edge error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
        end else if (err_clear) begin
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
        end else if (err_xfer_s) begin
            err_sticky_r <= 1'b1;
            if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            err_sticky_r <= err_sticky_r;
            err_count_r  <= err_count_r;
        end
    end

    assign out_valid  = s2_valid_r;
    assign out_index  = s2_idx_r;
    assign out_zero   = s2_zero_r;
    assign out_multi  = s2_multi_r;
    assign err_sticky = err_sticky_r;
    assign err_count  = err_count_r;

endmodule
